// File: rtl/proc_pkg.sv
// Shared definitions for the 20-bit pipelined processor.
// Holds the datapath width, MUL iteration count, opcode encodings,
// instruction field positions and the EX-stage FSM state type.
package proc_pkg;

    localparam int PROC_WIDTH      = 20;
    localparam int PROC_MUL_CYCLES = 20;

    // Instruction field positions
    localparam int OPC_HI = 19;
    localparam int OPC_LO = 16;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_MUL  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;

    typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
//   start        : load operands, clear accumulator and counter
//   run          : perform one iteration this edge
//   multiplicand : operand a
//   multiplier   : operand b
//   last         : the current iteration is the final one
//   product      : low WIDTH bits of a*b, valid while last is high
module seq_multiplier #(
    parameter int WIDTH      = 20,
    parameter int MUL_CYCLES = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] partial;

    // product includes the current iteration's partial term so the final
    // value can be written out on the same edge as the last iteration
    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign last    = (count == CW'(MUL_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= multiplicand;
            mplier <= multiplier;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: combinational ALU for single-cycle ops, iterative MUL with
// upstream stall, and the registered outputs feeding EX/MEM.
//   clock, reset             : clock, synchronous active-high reset
//   instruction              : instruction from ID/EX
//   read_data1, read_data2   : src1 / src2 operands from ID/EX
//   stall                    : hold IF/ID and ID/EX (combinational)
//   aluResult                : registered result or memory address
//   storeData                : registered src2 value (store data)
//   instructionOut           : registered instruction for EX/MEM
//   validOut                 : registered, outputs carry a real instruction
module execute_stage
    import proc_pkg::*;
#(
    parameter int WIDTH      = PROC_WIDTH,
    parameter int MUL_CYCLES = PROC_MUL_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    output logic             stall,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] storeData,
    output logic [WIDTH-1:0] instructionOut,
    output logic             validOut
);

    state_t           state;
    state_t           state_d;
    logic [3:0]       opcode;
    logic             is_mul;
    logic [WIDTH-1:0] imm_ext;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_valid;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] mul_instr;
    logic [WIDTH-1:0] mul_store;

    assign opcode  = instruction[OPC_HI:OPC_LO];
    assign is_mul  = (opcode == OP_MUL);
    assign imm_ext = {{(WIDTH-8){instruction[IMM_HI]}}, instruction[IMM_HI:IMM_LO]};
    assign shamt   = read_data2[4:0];

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock        (clock),
        .reset        (reset),
        .start        ((state == IDLE) && is_mul),
        .run          (state == BUSY),
        .multiplicand (read_data1),
        .multiplier   (read_data2),
        .last         (mul_last),
        .product      (mul_product)
    );

    // Single-cycle ALU; MUL, NOP and undefined opcodes leave alu_valid low
    always_comb begin
        alu_result = '0;
        alu_valid  = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_valid = 1'b1; alu_result = read_data1 + read_data2; end
            OP_SUB:  begin alu_valid = 1'b1; alu_result = read_data1 - read_data2; end
            OP_AND:  begin alu_valid = 1'b1; alu_result = read_data1 & read_data2; end
            OP_OR:   begin alu_valid = 1'b1; alu_result = read_data1 | read_data2; end
            OP_SLT:  begin
                alu_valid  = 1'b1;
                alu_result = {{(WIDTH-1){1'b0}}, ($signed(read_data1) < $signed(read_data2))};
            end
            OP_ADDI, OP_LD, OP_ST: begin
                alu_valid  = 1'b1;
                alu_result = read_data1 + imm_ext;
            end
            // shift amounts at or beyond the width flush to zero
            OP_SHL:  begin
                alu_valid = 1'b1;
                if (int'(shamt) < WIDTH) alu_result = read_data1 << shamt;
            end
            OP_SHR:  begin
                alu_valid = 1'b1;
                if (int'(shamt) < WIDTH) alu_result = read_data1 >> shamt;
            end
            default: ;
        endcase
    end

    // stall looks only at state, counter (via mul_last) and opcode
    always_comb begin
        state_d = state;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = !mul_last;
                if (mul_last) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Outputs default to a bubble every edge; only a finished op overrides
    always_ff @(posedge clock) begin
        if (reset) begin
            aluResult      <= '0;
            storeData      <= '0;
            instructionOut <= '0;
            validOut       <= 1'b0;
            mul_instr      <= '0;
            mul_store      <= '0;
        end else begin
            aluResult      <= '0;
            storeData      <= '0;
            instructionOut <= '0;
            validOut       <= 1'b0;
            if (state == IDLE) begin
                if (is_mul) begin
                    mul_instr <= instruction;
                    mul_store <= read_data2;
                end else if (alu_valid) begin
                    aluResult      <= alu_result;
                    storeData      <= read_data2;
                    instructionOut <= instruction;
                    validOut       <= 1'b1;
                end
            end else if (mul_last) begin
                aluResult      <= mul_product;
                storeData      <= mul_store;
                instructionOut <= mul_instr;
                validOut       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    localparam int  W = 20;
    localparam longint MASK = 64'hFFFFF;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] instruction, read_data1, read_data2;
    logic         stall;
    logic [W-1:0] aluResult, storeData, instructionOut;
    logic         validOut;

    int checks = 0;
    int errors = 0;

    execute_stage dut (
        .clock          (clock),
        .reset          (reset),
        .instruction    (instruction),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .stall          (stall),
        .aluResult      (aluResult),
        .storeData      (storeData),
        .instructionOut (instructionOut),
        .validOut       (validOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] ins;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        bit           exp_vld;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference from the opcode table, plain integer arithmetic
    function automatic void ref_op(input logic [W-1:0] ins, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] r,
                                   output bit v);
        longint la, lb, imm, sa, sb, sh;
        la  = longint'(a);
        lb  = longint'(b);
        imm = ins[7] ? longint'(ins[7:0]) - 256 : longint'(ins[7:0]);
        sa  = a[W-1] ? la - (MASK + 1) : la;
        sb  = b[W-1] ? lb - (MASK + 1) : lb;
        sh  = lb % 32;
        v   = 1'b1;
        case (ins[19:16])
            4'h1: r = W'((la + lb) & MASK);
            4'h2: r = W'((la - lb) & MASK);
            4'h3: r = W'(la & lb);
            4'h4: r = W'(la | lb);
            4'h5: r = (sa < sb) ? W'(1) : W'(0);
            4'h6, 4'hA, 4'hB: r = W'((la + imm) & MASK);
            4'h7: r = (sh >= W) ? W'(0) : W'((la << sh) & MASK);
            4'h8: r = (sh >= W) ? W'(0) : W'(la >> sh);
            4'h9: r = W'((la * lb) & MASK);
            default: begin r = '0; v = 1'b0; end
        endcase
    endfunction

    function automatic logic [W-1:0] mk(input logic [3:0] op, input logic [15:0] rest);
        return {op, rest};
    endfunction

    // Single-cycle op: stall must stay low, result one edge later
    task automatic run_single(input string tag, input logic [W-1:0] ins,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] er, input bit ev);
        instruction = ins; read_data1 = a; read_data2 = b;
        #1;
        chk({tag, " stall"}, stall, 0);
        @(posedge clock); #1;
        chk({tag, " aluResult"}, aluResult, er);
        chk({tag, " validOut"}, validOut, ev);
        chk({tag, " instructionOut"}, instructionOut, ev ? ins : '0);
        chk({tag, " storeData"}, storeData, ev ? b : '0);
    endtask

    // MUL: count stall cycles, bubbles in between, then the product
    task automatic run_mul(input string tag, input logic [W-1:0] ins,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er);
        int n = 0;
        bit bubbles_ok = 1'b1;
        instruction = ins; read_data1 = a; read_data2 = b;
        #1;
        while (stall && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (validOut !== 1'b0 || aluResult !== '0 || instructionOut !== '0)
                bubbles_ok = 1'b0;
        end
        chk({tag, " stall cycles"}, n, 20);
        chk({tag, " bubbles"}, bubbles_ok, 1);
        @(posedge clock); #1;
        chk({tag, " aluResult"}, aluResult, er);
        chk({tag, " instructionOut"}, instructionOut, ins);
        chk({tag, " validOut"}, validOut, 1);
    endtask

    initial begin
        logic [W-1:0] r, ins, a, b;
        bit v;

        // directed single-cycle table: {ins, a, b, expected, valid}
        vt.push_back('{mk(4'h1, 16'h1230), 20'h00005, 20'h00007, 20'h0000C, 1});
        vt.push_back('{mk(4'h2, 16'h0000), 20'h00003, 20'h00005, 20'hFFFFE, 1});
        vt.push_back('{mk(4'h5, 16'h0000), 20'hFFFFF, 20'h00001, 20'h00001, 1});
        vt.push_back('{mk(4'h5, 16'h0000), 20'h00001, 20'hFFFFF, 20'h00000, 1});
        vt.push_back('{mk(4'h6, 16'h0080), 20'h00100, 20'h00000, 20'h00080, 1});
        vt.push_back('{mk(4'hB, 16'h0004), 20'h00010, 20'h00ABC, 20'h00014, 1});
        vt.push_back('{mk(4'hA, 16'h00FF), 20'h00000, 20'h00000, 20'hFFFFF, 1});
        vt.push_back('{mk(4'h3, 16'h0000), 20'hF0F0F, 20'h0FF00, 20'h00F00, 1});
        vt.push_back('{mk(4'h4, 16'h0000), 20'hF0000, 20'h0000F, 20'hF000F, 1});
        vt.push_back('{mk(4'h7, 16'h0000), 20'h00001, 20'h00013, 20'h80000, 1});
        vt.push_back('{mk(4'h7, 16'h0000), 20'h00001, 20'h00014, 20'h00000, 1});
        vt.push_back('{mk(4'h8, 16'h0000), 20'h80000, 20'h00013, 20'h00001, 1});
        vt.push_back('{mk(4'h8, 16'h0000), 20'hFFFFF, 20'h0001F, 20'h00000, 1});
        vt.push_back('{mk(4'h1, 16'h0000), 20'hFFFFF, 20'h00001, 20'h00000, 1});
        vt.push_back('{mk(4'hF, 16'h1234), 20'h00005, 20'h00007, 20'h00000, 0});
        vt.push_back('{mk(4'h0, 16'h1234), 20'h00005, 20'h00007, 20'h00000, 0});
        vt.push_back('{mk(4'hC, 16'h0000), 20'h00005, 20'h00007, 20'h00000, 0});

        // reset state
        reset = 1'b1; instruction = '0; read_data1 = '0; read_data2 = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset stall", stall, 0);
        chk("reset aluResult", aluResult, 0);
        chk("reset storeData", storeData, 0);
        chk("reset instructionOut", instructionOut, 0);
        chk("reset validOut", validOut, 0);

        foreach (vt[i])
            run_single($sformatf("vec%0d", i), vt[i].ins, vt[i].a, vt[i].b,
                       vt[i].exp_res, vt[i].exp_vld);

        // MUL directed, then wrap case followed immediately by an ADD
        run_mul("mul 123x45", mk(4'h9, 16'h1230), 20'h00123, 20'h00045, 20'h04E6F);
        run_mul("mul wrap", mk(4'h9, 16'h0000), 20'h80000, 20'h00002, 20'h00000);
        run_single("add after mul", mk(4'h1, 16'h0000), 20'h00001, 20'h00001, 20'h00002, 1);
        // back-to-back MULs
        run_mul("mul b2b 1", mk(4'h9, 16'h0001), 20'hFFFFF, 20'hFFFFF, 20'h00001);
        run_mul("mul b2b 2", mk(4'h9, 16'h0002), 20'h00400, 20'h00400, 20'h00000);

        // reset in the 10th BUSY cycle
        instruction = mk(4'h9, 16'h0000); read_data1 = 20'h00123; read_data2 = 20'h00045;
        @(posedge clock); #1;          // now BUSY cycle 1
        repeat (9) @(posedge clock);   // BUSY cycle 10
        #1;
        chk("midmul stall", stall, 1);
        reset = 1'b1; instruction = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midmul reset stall", stall, 0);
        chk("midmul reset aluResult", aluResult, 0);
        chk("midmul reset instructionOut", instructionOut, 0);
        chk("midmul reset validOut", validOut, 0);
        run_single("add after reset", mk(4'h1, 16'h0000), 20'h00002, 20'h00002, 20'h00004, 1);

        // randomized single-cycle ops against the reference
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'h9) op = 4'h1;
            ins = {op, 16'($urandom)};
            a = W'($urandom); b = W'($urandom);
            ref_op(ins, a, b, r, v);
            run_single($sformatf("rnd%0d", i), ins, a, b, r, v);
        end

        // randomized MULs
        for (int i = 0; i < 4; i++) begin
            ins = {4'h9, 16'($urandom)};
            a = W'($urandom); b = W'($urandom);
            ref_op(ins, a, b, r, v);
            run_mul($sformatf("rmul%0d", i), ins, a, b, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
